// File: rtl/cmp_pkg.sv
// cmp_pkg: FSM/result encodings and counter sizing shared by serial_mag_comparator.
package cmp_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    typedef enum logic [1:0] {RES_NONE, RES_EQ, RES_GT, RES_LT} res_e;
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
endpackage

// File: rtl/bit1_cmp_cell.sv
// bit1_cmp_cell: 1-bit magnitude compare; inv_sense swaps the sense for a two's-complement sign bit.
module bit1_cmp_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic inv_sense,
    output logic bgt,
    output logic blt
);
    always_comb begin
        bgt = inv_sense ? (~a_bit & b_bit) : (a_bit & ~b_bit);
        blt = inv_sense ? (a_bit & ~b_bit) : (~a_bit & b_bit);
    end
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first bit-serial EQ/GT/LT compare with a one-cycle done pulse.
// Define EARLY_EXIT_EN to finish on the edge that consumes the first differing bit.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    res_e             dec_q, dec_d, res_q, res_d, dec_n;
    logic             bgt, blt, finish;

    // Operands shift left, so the bit under test is always the top bit
    bit1_cmp_cell u_cell (
        .a_bit     (a_q[WIDTH-1]),
        .b_bit     (b_q[WIDTH-1]),
        .inv_sense (SIGNED && (cnt_q == CNT_TOP)),
        .bgt       (bgt),
        .blt       (blt)
    );

    always_comb begin
        dec_n = (dec_q != RES_NONE) ? dec_q : bgt ? RES_GT : blt ? RES_LT : RES_NONE;
`ifdef EARLY_EXIT_EN
        finish = (cnt_q == '0) || (dec_n != RES_NONE);
`else
        finish = (cnt_q == '0);
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dec_d   = dec_q;
        res_d   = res_q;
        if (state_q != ST_CMP && start) begin
            state_d = ST_CMP;
            cnt_d   = CNT_TOP;
            a_d     = a;
            b_d     = b;
            dec_d   = RES_NONE;
            res_d   = RES_NONE;
        end else if (state_q == ST_CMP) begin
            cnt_d = cnt_q - CNT_W'(1);
            a_d   = a_q << 1;
            b_d   = b_q << 1;
            dec_d = dec_n;
            if (finish) begin
                state_d = ST_DONE;
                res_d   = (dec_n == RES_NONE) ? RES_EQ : dec_n;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dec_q   <= RES_NONE;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == ST_CMP);
    assign done = (state_q == ST_DONE);
    assign eq   = (res_q == RES_EQ);
    assign gt   = (res_q == RES_GT);
    assign lt   = (res_q == RES_LT);
endmodule
